// File: rtl/audio_pkg.sv
// Shared types and sample arithmetic for the I2S audio transmitter.
//
// Contents:
//   vol_t      2-bit volume code (mute, quarter, half, full)
//   aud_t      32-bit signed working format; samples are MSB-aligned into it
//   vol_scale  arithmetic right shift by volume code, sign preserved
//   downmix    L/R to mono
//
// Configuration macro: AUDIO_SAT_EN
//   defined   : downmix = L+R with one guard bit, clamped to the sample range
//   undefined : downmix = (L+R)>>>1, which can never overflow
//
// Samples are MSB-aligned in aud_t so that both functions work for any
// SAMPLE_W <= 32 without a width argument. The caller keeps the top
// SAMPLE_W bits. Saturation at the full 32-bit range then matches
// saturation at the sample range.
package audio_pkg;

  typedef enum logic [1:0] {
    VOL_MUTE = 2'd0,
    VOL_QTR  = 2'd1,
    VOL_HALF = 2'd2,
    VOL_FULL = 2'd3
  } vol_t;

  localparam int AUD_W = 32;
  typedef logic signed [AUD_W-1:0] aud_t;

  function automatic aud_t vol_scale(input aud_t sample, input vol_t vol);
    aud_t res;
    case (vol)
      VOL_MUTE: res = '0;
      VOL_QTR:  res = sample >>> 2;
      VOL_HALF: res = sample >>> 1;
      default:  res = sample;
    endcase
    return res;
  endfunction

  function automatic aud_t downmix(input aud_t l, input aud_t r);
    logic signed [AUD_W:0] sum;
    sum = {l[AUD_W-1], l} + {r[AUD_W-1], r};
`ifdef AUDIO_SAT_EN
    // The guard bit disagrees with the sign bit only when the sum
    // overflowed; in that case clamp toward the sign of the true result.
    if (sum[AUD_W] != sum[AUD_W-1]) begin
      return sum[AUD_W] ? {1'b1, {(AUD_W-1){1'b0}}} : {1'b0, {(AUD_W-1){1'b1}}};
    end
    return aud_t'(sum);
`else
    return aud_t'(sum >>> 1);
`endif
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Run-time programmable I2S bit clock divider.
//
// Ports:
//   clk          in   system clock
//   reset_n      in   synchronous reset, active low
//   bck_div_i    in   bit clock half-period in clk cycles minus 1
//   bck_o        out  bit clock (registered)
//   fall_tick_o  out  high in the cycle whose clk edge drives bck_o 1->0
module i2s_bclk_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] bck_div_i,
  output logic             bck_o,
  output logic             fall_tick_o
);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             bck_q, bck_d;
  logic             hit;

  // >= rather than == so that lowering bck_div below the current count
  // takes effect at the very next compare.
  assign hit = (div_cnt_q >= bck_div_i);

  always_comb begin
    div_cnt_d = hit ? '0 : div_cnt_q + 1'b1;
    bck_d     = hit ? ~bck_q : bck_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
      bck_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bck_q     <= bck_d;
    end
  end

  assign bck_o       = bck_q;
  assign fall_tick_o = hit && bck_q;

endmodule

// File: rtl/i2s_audio_tx.sv
// Philips-I2S transmitter with a valid/ready sample input, volume and
// optional mono downmix.
//
// Ports:
//   clk, reset_n        clock and synchronous active-low reset
//   bck_div             bit clock half-period in clk cycles minus 1
//   volume              0 mute, 1 >>>2, 2 >>>1, 3 full
//   in_l, in_r          signed PCM sample pair
//   in_valid, in_ready  handshake; the pair transfers when both are high
//   hp_bck, hp_ws       bit clock and word select (0 = left)
//   hp_din              serial data, MSB first, one bck behind ws
//   frame_start         1-clk pulse at every frame load
//   underrun            1-clk pulse when a load found no pending pair
//
// Configuration macro: AUDIO_SAT_EN selects the saturating downmix in
// audio_pkg. It only matters when STEREO = 0.
module i2s_audio_tx
  import audio_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W   = 16,
  parameter int DIV_W    = 8,
  parameter int STEREO   = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [DIV_W-1:0]    bck_div,
  input  logic [1:0]          volume,
  input  logic [SAMPLE_W-1:0] in_l,
  input  logic [SAMPLE_W-1:0] in_r,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                hp_bck,
  output logic                hp_ws,
  output logic                hp_din,
  output logic                frame_start,
  output logic                underrun
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int BC_W    = $clog2(FRAME_W);

  if (SLOT_W < SAMPLE_W) begin : g_bad_slot
    $error("i2s_audio_tx: SLOT_W must be >= SAMPLE_W");
  end
  if (SAMPLE_W > AUD_W) begin : g_bad_sample
    $error("i2s_audio_tx: SAMPLE_W must be <= 32");
  end

  logic fall_tick;

  i2s_bclk_gen #(.DIV_W(DIV_W)) u_bclk (
    .clk        (clk),
    .reset_n    (reset_n),
    .bck_div_i  (bck_div),
    .bck_o      (hp_bck),
    .fall_tick_o(fall_tick)
  );

  // Input processing: align, scale, optionally downmix.
  aud_t                l_vol, r_vol, mono;
  logic [SAMPLE_W-1:0] proc_l, proc_r;
  logic                unused_bits;

  assign l_vol = vol_scale(aud_t'(in_l) << (AUD_W - SAMPLE_W), vol_t'(volume));
  assign r_vol = vol_scale(aud_t'(in_r) << (AUD_W - SAMPLE_W), vol_t'(volume));
  assign mono  = downmix(l_vol, r_vol);
  // Bits below the sample width are not kept. In stereo builds the mono
  // result is not used at all.
  assign unused_bits = ^{l_vol, r_vol, mono};

  if (STEREO != 0) begin : g_stereo
    assign proc_l = l_vol[AUD_W-1 -: SAMPLE_W];
    assign proc_r = r_vol[AUD_W-1 -: SAMPLE_W];
  end else begin : g_mono
    assign proc_l = mono[AUD_W-1 -: SAMPLE_W];
    assign proc_r = mono[AUD_W-1 -: SAMPLE_W];
  end

  // State
  logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic [SAMPLE_W-1:0] pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic                pend_full_q, pend_full_d;
  logic                in_ready_q, hp_ws_q, hp_ws_d, hp_din_q, hp_din_d;
  logic                frame_start_q, underrun_q;
  logic                wrap, load, accept;
  logic [SLOT_W-1:0]   slot_l, slot_r;

  // Each slot carries the sample MSB-aligned, with zero padding below.
  assign slot_l = SLOT_W'(pend_l_q) << (SLOT_W - SAMPLE_W);
  assign slot_r = SLOT_W'(pend_r_q) << (SLOT_W - SAMPLE_W);

  always_comb begin
    wrap   = (bit_cnt_q == BC_W'(FRAME_W - 1));
    load   = fall_tick && wrap;
    accept = in_valid && in_ready_q;

    bit_cnt_d = bit_cnt_q;
    if (fall_tick) begin
      bit_cnt_d = wrap ? '0 : bit_cnt_q + 1'b1;
    end

    frame_d     = frame_q;
    pend_l_d    = pend_l_q;
    pend_r_d    = pend_r_q;
    pend_full_d = pend_full_q;

    // On an empty load the previous frame is kept and repeated.
    if (load && pend_full_q) begin
      frame_d     = {slot_l, slot_r};
      pend_full_d = 1'b0;
    end
    // accept needs in_ready, so it can never meet a load that drains a
    // full pending register. A sample arriving at an empty load waits for
    // the next frame.
    if (accept) begin
      pend_l_d    = proc_l;
      pend_r_d    = proc_r;
      pend_full_d = 1'b1;
    end

    // ws is raised one bit early so it leads each slot's MSB by one bck.
    hp_din_d = frame_d[BC_W'(FRAME_W - 1) - bit_cnt_d];
    hp_ws_d  = (bit_cnt_d >= BC_W'(SLOT_W - 1)) && (bit_cnt_d <= BC_W'(FRAME_W - 2));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bit_cnt_q     <= '0;
      frame_q       <= '0;
      pend_l_q      <= '0;
      pend_r_q      <= '0;
      pend_full_q   <= 1'b0;
      in_ready_q    <= 1'b0;
      hp_ws_q       <= 1'b0;
      hp_din_q      <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      bit_cnt_q     <= bit_cnt_d;
      frame_q       <= frame_d;
      pend_l_q      <= pend_l_d;
      pend_r_q      <= pend_r_d;
      pend_full_q   <= pend_full_d;
      in_ready_q    <= !pend_full_d;
      hp_ws_q       <= hp_ws_d;
      hp_din_q      <= hp_din_d;
      frame_start_q <= load;
      underrun_q    <= load && !pend_full_q;
    end
  end

  assign in_ready    = in_ready_q;
  assign hp_ws       = hp_ws_q;
  assign hp_din      = hp_din_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule
